// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: switch bus between the raw slide switches, the debouncer and the divider select.
//   switch_in  [W]  raw asynchronous switch levels (driven by master)
//   switch_out [W]  debounced, registered switch value (driven by slave)
//   changed         one-cycle strobe on every accepted update (driven by slave)
//   settling        high while a candidate value is being timed (driven by slave)
interface switch_debouncer_if #(
   parameter int W = 2
);
   logic [W-1:0] switch_in;
   logic [W-1:0] switch_out;
   logic         changed;
   logic         settling;
   modport master (output switch_in, input switch_out, changed, settling);
   modport slave (input switch_in, output switch_out, changed, settling);
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises a raw switch vector and accepts a new value only after it holds stable.
//   clk  system clock, the only clock
//   rst  synchronous, active-high reset
//   bus  slave side of switch_debouncer_if: switch_in in; switch_out, changed, settling out
module switch_debouncer #(
   parameter int W               = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input logic               clk,
   input logic               rst,
   switch_debouncer_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   typedef enum logic {STABLE, SETTLING} state_t;
   state_t           state;
   logic [W-1:0]     sync_1;
   logic [W-1:0]     sync_2;
   logic [W-1:0]     candidate;
   logic [W-1:0]     value;
   logic [CNT_W-1:0] cnt;
   logic             strobe;
   logic             busy;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= STABLE;
         sync_1    <= '0;
         sync_2    <= '0;
         candidate <= '0;
         value     <= '0;
         cnt       <= '0;
         strobe    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sync_1 <= bus.switch_in;
         sync_2 <= sync_1;
         strobe <= 1'b0;
         if (state == STABLE) begin
            if (sync_2 != value) begin
               candidate <= sync_2;
               cnt       <= '0;
               state     <= SETTLING;
               busy      <= 1'b1;
            end
         end else if (sync_2 == value) begin
            // input fell back to the accepted value: the excursion was a glitch
            cnt   <= '0;
            state <= STABLE;
            busy  <= 1'b0;
         end else if (sync_2 != candidate) begin
            // a different new value restarts the window, so intermediate codes never leak out
            candidate <= sync_2;
            cnt       <= '0;
         end else if (cnt == LAST) begin
            value  <= candidate;
            strobe <= 1'b1;
            cnt    <= '0;
            state  <= STABLE;
            busy   <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
   assign bus.switch_out = value;
   assign bus.changed    = strobe;
   assign bus.settling   = busy;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: randomized and directed checks of switch_debouncer against a run-length reference model.
//   Two instances share clk/rst/switch_in: d4 (DEBOUNCE_CYCLES=4, CNT_W=3) and d1 (DEBOUNCE_CYCLES=1, CNT_W=1).
module tb_switch_debouncer;
   logic       clk;
   logic       rst;
   logic [1:0] sw;
   int         errors;
   int         checks;
   switch_debouncer_if #(.W(2)) b4 ();
   switch_debouncer_if #(.W(2)) b1 ();
   assign b4.switch_in = sw;
   assign b1.switch_in = sw;
   switch_debouncer #(.W(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
   switch_debouncer #(.W(2), .DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // Reference model: the value seen by the decision logic lags the pin by two edges; an
   // output update happens when the same value has been seen on DEBOUNCE_CYCLES+1 consecutive
   // edges and differs from the current output. Settling means "seen value differs from output".
   int         dcs [2] = '{4, 1};
   logic [1:0] m_s1 [2];
   logic [1:0] m_s2 [2];
   logic [1:0] m_prev [2];
   logic [1:0] m_out [2];
   int         m_run [2];
   logic       m_chg [2];
   logic       m_set [2];
   task automatic model_step();
      logic [1:0] seen;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_s1[d] = 2'b00; m_s2[d] = 2'b00; m_prev[d] = 2'b00; m_out[d] = 2'b00;
            m_run[d] = 1; m_chg[d] = 1'b0; m_set[d] = 1'b0;
         end else begin
            seen = m_s2[d];
            m_s2[d] = m_s1[d];
            m_s1[d] = sw;
            m_run[d] = (seen == m_prev[d]) ? ((m_run[d] < 1000) ? m_run[d] + 1 : m_run[d]) : 1;
            m_prev[d] = seen;
            m_chg[d] = (m_run[d] == dcs[d] + 1) && (seen != m_out[d]);
            if (m_chg[d]) m_out[d] = seen;
            m_set[d] = (seen != m_out[d]);
         end
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask
   task automatic test_reset();
      sw = 2'b00; rst = 1'b1;
      tick(); tick();
      checks++;
      if ({b4.switch_out, b4.changed, b4.settling} !== 4'b0000 || {b1.switch_out, b1.changed, b1.settling} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state: d4=%b d1=%b required 0000", {b4.switch_out, b4.changed, b4.settling}, {b1.switch_out, b1.changed, b1.settling});
      end
      rst = 1'b0;
      repeat (20) begin
         tick();
         checks++;
         if ({b4.switch_out, b4.changed, b4.settling} !== 4'b0000 || {b1.switch_out, b1.changed, b1.settling} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: d4=%b d1=%b required 0000", {b4.switch_out, b4.changed, b4.settling}, {b1.switch_out, b1.changed, b1.settling});
         end
      end
   endtask
   task automatic test_step();
      sw = 2'b10;
      for (int e = 1; e <= 9; e++) begin
         tick();
         checks++;
         if (b4.switch_out !== (e >= 7 ? 2'b10 : 2'b00) || b4.changed !== (e == 7) || b4.settling !== (e >= 3 && e < 7)) begin
            errors++;
            $display("FAIL step_d4 edge %0d: out=%b chg=%b set=%b required out=%b chg=%b set=%b", e,
                     b4.switch_out, b4.changed, b4.settling, (e >= 7 ? 2'b10 : 2'b00), e == 7, e >= 3 && e < 7);
         end
         checks++;
         if ({b1.switch_out, b1.changed, b1.settling} !== {m_out[1], m_chg[1], m_set[1]}) begin
            errors++;
            $display("FAIL step_d1 edge %0d: got %b required %b", e, {b1.switch_out, b1.changed, b1.settling}, {m_out[1], m_chg[1], m_set[1]});
         end
      end
   endtask
   task automatic test_bounce();
      int pulses;
      sw = 2'b00;
      repeat (12) tick();
      checks++;
      if (b4.switch_out !== 2'b00) begin
         errors++;
         $display("FAIL bounce_pre: out=%b required 00", b4.switch_out);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         sw = (i < 2) ? 2'b01 : 2'b00;
         tick();
         if (b4.changed === 1'b1) pulses++;
         checks++;
         if (b4.switch_out !== 2'b00) begin
            errors++;
            $display("FAIL bounce_out cycle %0d: out=%b required 00", i, b4.switch_out);
         end
         checks++;
         if ({b1.switch_out, b1.changed, b1.settling} !== {m_out[1], m_chg[1], m_set[1]}) begin
            errors++;
            $display("FAIL bounce_d1 cycle %0d: got %b required %b", i, {b1.switch_out, b1.changed, b1.settling}, {m_out[1], m_chg[1], m_set[1]});
         end
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL bounce_pulses: got %0d required 0", pulses);
      end
   endtask
   task automatic test_swap();
      int pulses;
      logic saw01;
      pulses = 0; saw01 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         sw = (i < 3) ? 2'b01 : 2'b11;
         tick();
         if (b4.changed === 1'b1) pulses++;
         if (b4.switch_out === 2'b01) saw01 = 1'b1;
         checks++;
         if ({b4.switch_out, b4.changed, b4.settling} !== {m_out[0], m_chg[0], m_set[0]}) begin
            errors++;
            $display("FAIL swap_d4 cycle %0d: got %b required %b", i, {b4.switch_out, b4.changed, b4.settling}, {m_out[0], m_chg[0], m_set[0]});
         end
      end
      checks++;
      if (pulses != 1 || saw01 !== 1'b0 || b4.switch_out !== 2'b11) begin
         errors++;
         $display("FAIL swap_summary: pulses=%0d saw01=%b out=%b required 1 0 11", pulses, saw01, b4.switch_out);
      end
   endtask
   task automatic test_reset_mid();
      sw = 2'b00;
      repeat (12) tick();
      sw = 2'b01;
      repeat (5) tick();
      checks++;
      if (b4.settling !== 1'b1 || b4.switch_out !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_pre: set=%b out=%b required 1 00", b4.settling, b4.switch_out);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({b4.switch_out, b4.changed, b4.settling} !== 4'b0000 || {b1.switch_out, b1.changed, b1.settling} !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_reset: d4=%b d1=%b required 0000", {b4.switch_out, b4.changed, b4.settling}, {b1.switch_out, b1.changed, b1.settling});
      end
      rst = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         checks++;
         if (b4.switch_out !== (e >= 7 ? 2'b01 : 2'b00) || b4.changed !== (e == 7)) begin
            errors++;
            $display("FAIL rstmid_d4 edge %0d: out=%b chg=%b required out=%b chg=%b", e, b4.switch_out, b4.changed, (e >= 7 ? 2'b01 : 2'b00), e == 7);
         end
         checks++;
         if ({b1.switch_out, b1.changed, b1.settling} !== {m_out[1], m_chg[1], m_set[1]}) begin
            errors++;
            $display("FAIL rstmid_d1 edge %0d: got %b required %b", e, {b1.switch_out, b1.changed, b1.settling}, {m_out[1], m_chg[1], m_set[1]});
         end
      end
   endtask
   task automatic test_dc1_walk();
      logic [1:0] v;
      logic [1:0] prev;
      int pulses;
      sw = 2'b00;
      repeat (10) tick();
      sw = 2'b11;
      for (int e = 1; e <= 5; e++) begin
         tick();
         checks++;
         if (b1.switch_out !== (e >= 4 ? 2'b11 : 2'b00) || b1.changed !== (e == 4)) begin
            errors++;
            $display("FAIL dc1_step edge %0d: out=%b chg=%b required out=%b chg=%b", e, b1.switch_out, b1.changed, (e >= 4 ? 2'b11 : 2'b00), e == 4);
         end
      end
      prev = 2'b11;
      for (int i = 1; i <= 4; i++) begin
         v = 2'(i + 3);
         sw = v;
         pulses = 0;
         repeat (10) begin
            tick();
            if (b1.changed === 1'b1) pulses++;
         end
         checks++;
         if (b1.switch_out !== v || pulses != (v != prev ? 1 : 0)) begin
            errors++;
            $display("FAIL dc1_walk value %b: out=%b pulses=%0d required out=%b pulses=%0d", v, b1.switch_out, pulses, v, v != prev ? 1 : 0);
         end
         prev = v;
      end
   endtask
   task automatic test_random();
      for (int s = 0; s < 60; s++) begin
         sw = 2'($urandom_range(0, 3));
         for (int h = $urandom_range(1, 8); h > 0; h--) begin
            rst = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if ({b4.switch_out, b4.changed, b4.settling} !== {m_out[0], m_chg[0], m_set[0]}) begin
               errors++;
               $display("FAIL random_d4 seg %0d: got %b required %b", s, {b4.switch_out, b4.changed, b4.settling}, {m_out[0], m_chg[0], m_set[0]});
            end
            checks++;
            if ({b1.switch_out, b1.changed, b1.settling} !== {m_out[1], m_chg[1], m_set[1]}) begin
               errors++;
               $display("FAIL random_d1 seg %0d: got %b required %b", s, {b1.switch_out, b1.changed, b1.settling}, {m_out[1], m_chg[1], m_set[1]});
            end
         end
      end
      rst = 1'b0;
   endtask
   initial begin
      errors = 0;
      checks = 0;
      sw = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_step();
      test_bounce();
      test_swap();
      test_reset_mid();
      test_dc1_walk();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
